// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg                                                             |
// | Shared widths and depth for the 1024x8 synchronous FIFO.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fifo_pkg;
   localparam int DW    = 8;
   localparam int AW    = 10;
   localparam int PW    = AW + 1;
   localparam int DEPTH = 1 << AW;
endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_1024x8_ptr_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ptr_cnt                                                              |
// | Enabled wrap-around incrementer used as a FIFO read/write pointer.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ptr_cnt
   import fifo_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [PW-1:0] q
);

   logic [PW-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= r_q + 1'b1;
      end
   end

   assign q = r_q;

endmodule : ptr_cnt
`default_nettype wire

// File: rtl/fifo_1024x8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_1024x8                                                          |
// | Single-clock 1024-entry x 8-bit FIFO with registered read data.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_1024x8
   import fifo_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] din,
   input  logic          rd_en,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [PW-1:0] count,
   output logic          overflow,
   output logic          underflow
);

   logic [PW-1:0] w_wptr;
   logic [PW-1:0] w_rptr;
   logic          w_full;
   logic          w_empty;
   logic          w_wr_acc;
   logic          w_rd_acc;

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_dout;
   logic          r_overflow;
   logic          r_underflow;

   // Equal indices with differing wrap bits means the writer is a full lap ahead.
   assign w_empty  = (w_wptr == w_rptr);
   assign w_full   = (w_wptr[AW] != w_rptr[AW]) && (w_wptr[AW-1:0] == w_rptr[AW-1:0]);
   assign w_wr_acc = wr_en && !w_full;
   assign w_rd_acc = rd_en && !w_empty;

   ptr_cnt u_wptr (
      .clk (clk),
      .rst (rst),
      .en  (w_wr_acc),
      .q   (w_wptr)
   );

   ptr_cnt u_rptr (
      .clk (clk),
      .rst (rst),
      .en  (w_rd_acc),
      .q   (w_rptr)
   );

   always_ff @(posedge clk) begin
      if (w_wr_acc && !rst) begin
         r_mem[w_wptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout      <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= wr_en && w_full;
         r_underflow <= rd_en && w_empty;
         if (w_rd_acc) begin
            r_dout <= r_mem[w_rptr[AW-1:0]];
         end
      end
   end

   assign dout      = r_dout;
   assign full      = w_full;
   assign empty     = w_empty;
   assign count     = w_wptr - w_rptr;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule : fifo_1024x8
`default_nettype wire

// File: tb/tb_fifo_1024x8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_1024x8                                                       |
// | Queue-model self-checking bench for fifo_1024x8.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fifo_1024x8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        rd_en = 1'b0;
   logic [7:0]  dout;
   logic        full;
   logic        empty;
   logic [10:0] count;
   logic        overflow;
   logic        underflow;

   fifo_1024x8 dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .din       (din),
      .rd_en     (rd_en),
      .dout      (dout),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   bit         chk_en  = 1'b0;

   logic [7:0] m_q[$];
   logic [7:0] m_dout = 8'h00;
   bit         m_ovf  = 1'b0;
   bit         m_unf  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference behaviour: rules evaluated on occupancy before the edge.
   task automatic model_edge(input bit w, input logic [7:0] d, input bit r, input bit rs);
      int sz;
      if (rs) begin
         m_q.delete();
         m_dout = 8'h00;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else begin
         sz    = m_q.size();
         m_ovf = w && (sz == 1024);
         m_unf = r && (sz == 0);
         if (r && sz > 0) m_dout = m_q.pop_front();
         if (w && sz < 1024) m_q.push_back(d);
      end
   endtask

   task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit rs);
      wr_en = w;
      din   = d;
      rd_en = r;
      rst   = rs;
      @(posedge clk);
      model_edge(w, d, r, rs);
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("empty",     int'(empty),     int'(m_q.size() == 0));
         chk("full",      int'(full),      int'(m_q.size() == 1024));
         chk("count",     int'(count),     m_q.size());
         chk("dout",      int'(dout),      int'(m_dout));
         chk("overflow",  int'(overflow),  int'(m_ovf));
         chk("underflow", int'(underflow), int'(m_unf));
      end
   end

   initial begin
      int wrote;
      cyc(0, 8'h00, 0, 1);
      cyc(0, 8'h00, 0, 1);
      cyc(0, 8'h00, 0, 0);
      chk_en = 1'b1;
      chk("rst_empty", int'(empty), 1);
      chk("rst_full",  int'(full), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_dout",  int'(dout), 8'h00);

      cyc(0, 8'h00, 1, 0);
      chk("unf_pulse", int'(underflow), 1);
      chk("unf_dout",  int'(dout), 8'h00);
      cyc(0, 8'h00, 0, 0);
      chk("unf_clear", int'(underflow), 0);

      cyc(1, 8'hA1, 0, 0);
      cyc(1, 8'hB2, 0, 0);
      cyc(1, 8'hC3, 0, 0);
      chk("cnt3", int'(count), 3);
      cyc(0, 8'h00, 1, 0); chk("rdA1", int'(dout), 8'hA1);
      cyc(0, 8'h00, 1, 0); chk("rdB2", int'(dout), 8'hB2);
      cyc(0, 8'h00, 1, 0); chk("rdC3", int'(dout), 8'hC3);
      chk("cnt0", int'(count), 0);
      chk("empty_end", int'(empty), 1);

      for (int i = 0; i < 1024; i++) cyc(1, 8'(i), 0, 0);
      chk("fill_full",  int'(full), 1);
      chk("fill_count", int'(count), 11'h400);
      cyc(1, 8'hEE, 0, 0);
      chk("ovf_pulse", int'(overflow), 1);
      chk("ovf_count", int'(count), 11'h400);
      for (int i = 0; i < 1024; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk("drain_data", int'(dout), i & 8'hFF);
      end
      chk("drain_empty", int'(empty), 1);

      for (int i = 0; i < 5; i++) cyc(1, 8'(8'h30 + i), 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 8'($urandom), 1, 0);
      chk("both_cnt5", int'(count), 5);
      for (int i = 0; i < 1019; i++) cyc(1, 8'($urandom), 0, 0);
      chk("full_again", int'(full), 1);
      cyc(1, 8'h77, 1, 0);
      chk("full_both_cnt", int'(count), 1023);
      chk("full_both_ovf", int'(overflow), 1);

      cyc(0, 8'h00, 0, 1);
      wrote = 0;
      while (wrote < 3000) begin
         for (int i = 0; i < 7 && wrote < 3000; i++) begin
            cyc(1, 8'($urandom), 0, 0);
            wrote++;
         end
         for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0);
      end
      while (m_q.size() > 0) cyc(0, 8'h00, 1, 0);

      for (int i = 0; i < 6000; i++) begin
         if (i < 3000) cyc($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 30, 0);
         else          cyc($urandom_range(0, 99) < 30, 8'($urandom), $urandom_range(0, 99) < 70, 0);
      end

      cyc(0, 8'h00, 0, 1);
      for (int i = 0; i < 600; i++) cyc(1, 8'($urandom), 0, 0);
      chk("cnt600", int'(count), 600);
      cyc(1, 8'h99, 1, 1);
      chk("mid_rst_empty", int'(empty), 1);
      chk("mid_rst_count", int'(count), 0);
      chk("mid_rst_dout",  int'(dout), 8'h00);
      cyc(1, 8'h5A, 0, 0);
      cyc(0, 8'h00, 1, 0);
      chk("post_rst_5A", int'(dout), 8'h5A);

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_fifo_1024x8
`default_nettype wire

// File: doc/fifo_1024x8.md
# fifo_1024x8

Synchronous 1024-entry × 8-bit FIFO buffer that sits directly downstream of the team's 11-bit enabled incrementer. It holds one 11-bit write pointer and one 11-bit read pointer, each an instance of that style of counter. It consumes their outputs to address the storage array and to derive full/empty/occupancy. It is the data-path stage of the FIFO_2x10_8bit design: producer writes bytes in, consumer reads them out, and both share one clock.

## Interface
- DW, 8, data width in bits
- AW, 10, address width; depth = 2^AW = 1024
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  reset, synchronous, active-high
- wr_en  input  1  write request; din captured when accepted
- din  input  DW  write data
- rd_en  input  1  read request
- dout  output  DW  registered read data
- full  output  1  FIFO holds 1024 entries
- empty  output  1  FIFO holds 0 entries
- count  output  AW+1  current occupancy, 0..1024
- overflow  output  1  one-cycle pulse: write requested while full
- underflow  output  1  one-cycle pulse: read requested while empty

## Operation
- Pointers: wptr, rptr, each AW+1 = 11 bits. The low AW bits address memory. The MSB is the wrap bit.
- Write accept: wr_acc = wr_en & ~full. On accept, mem[wptr[AW-1:0]] <= din and wptr <= wptr + 1.
- Read accept: rd_acc = rd_en & ~empty. On accept, dout <= mem[rptr[AW-1:0]] and rptr <= rptr + 1. Without an accept, dout holds its value.
- empty = (wptr == rptr). Combinational from registered pointers.
- full = (wptr[AW] != rptr[AW]) & (wptr[AW-1:0] == rptr[AW-1:0]). Combinational.
- count = wptr - rptr, modulo 2^(AW+1). Unsigned. 1024 is represented as 11'h400.
- Simultaneous wr_en & rd_en:
  - Not full, not empty: both accepted; count unchanged.
  - Empty: only the write is accepted; underflow pulses.
  - Full: only the read is accepted; overflow pulses. There is no pass-through and no write-when-full-with-read.
- Rejected requests change no pointer, no memory and no dout.
- Wrap-around: pointers increment modulo 2048 with no special case. The memory index wraps at 1024.
- overflow <= wr_en & full; underflow <= rd_en & empty. Both are registered and asserted the cycle after the request.

## Timing
- Reset: rst high at a clk edge sets wptr = rptr = 0, dout = 0, overflow = underflow = 0. Outputs then read empty = 1, full = 0, count = 0. Memory contents are not reset.
- Reset mid-operation: all stored data is discarded and the FIFO reads empty in the cycle after the reset edge. Requests in the reset cycle are ignored.
- Write-to-flag latency: 1 cycle. empty drops and count increments after the accepting edge.
- Read latency: 1 cycle. dout is valid from the edge that accepts rd_en until the next accepted read.
- Write-to-read: data written at edge k is readable with rd_en sampled at edge k+1, and appears on dout after edge k+1.
- No combinational path from din to dout. full/empty/count depend only on registers.

## Structure
- Shared package fifo_pkg: DW = 8, AW = 10, PW = AW+1, DEPTH = 1 << AW.
- Sub-module ptr_cnt with ports q[PW-1:0], en, clk, rst. It is an 11-bit enabled incrementer with synchronous active-high reset to 0. Two instances: the write pointer (en = wr_acc) and the read pointer (en = rd_acc).
- Memory: an inferred DEPTH×DW register array with a synchronous write port and a registered read port.

## Test plan
- Reset → empty = 1, full = 0, count = 0, dout = 8'h00. Then rd_en for 1 cycle → underflow pulses 1 cycle later; rptr and dout unchanged.
- Write 8'hA1, 8'hB2, 8'hC3, then read 3 → dout = A1, B2, C3 on consecutive cycles, each 1 cycle after its read; count 3→0; empty = 1 at the end.
- Write 1024 bytes of value i & 8'hFF → full = 1, count = 11'h400. One more write of 8'hEE → overflow pulse and count unchanged. Drain all 1024 → data 00..FF repeated, with no EE.
- At count = 5, assert wr_en & rd_en for 10 cycles → count stays 5 and reads return in FIFO order. When full, wr & rd together → count becomes 1023 and overflow = 1.
- Stream 3000 bytes with alternating write/read bursts of 7 and 5 → pointer MSBs toggle and every byte is read back in order. full/empty are never wrongly asserted at the 1023→0 index wrap.
- With count = 600, assert rst for 1 cycle while wr_en = rd_en = 1 → next cycle empty = 1, count = 0, dout = 0. A subsequent write/read of 8'h5A returns 8'h5A.
